// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (port A, priority,
// zero latency) and a DMA/debug requester (port B, req/ack, registered data).
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_req,
  input  logic                          a_we,
  input  logic [AW-1:0]                 a_addr,
  input  logic [DW-1:0]                 a_wdata,
  output logic [DW-1:0]                 a_rdata,
  output logic                          a_stall,
  input  logic                          b_req,
  input  logic                          b_we,
  input  logic [AW-1:0]                 b_addr,
  input  logic [DW-1:0]                 b_wdata,
  output logic [DW-1:0]                 b_rdata,
  output logic                          b_ack,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata,
  output logic                          dbg_bst,
  output logic [$clog2(MAX_WAIT+1)-1:0] dbg_wait_cnt
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic {B_IDLE = 1'b0, B_ACK = 1'b1} bst_t;

  bst_t           bst, bst_nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic           force_b, gnt_b;

  // Handshake: B raises b_req and holds it with its command stable until the
  // cycle b_ack=1; b_rdata is valid only in that cycle. A is a plain request
  // that must be held while a_stall=1; its access happens in any unstalled cycle.
  always_comb begin
    force_b = (bst == B_IDLE) && b_req && (wait_cnt == WAIT_MAX);
    gnt_b   = (bst == B_IDLE) && b_req && (!a_req || force_b);
    a_stall = a_req && gnt_b;
    a_rdata = mem_rdata;
    b_ack   = (bst == B_ACK);

    if (gnt_b) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_we    = b_we;
    end else begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_we    = a_req && a_we;
    end
    // Keep memory untouched while reset is asserted, even mid-grant.
    if (rst) mem_we = 1'b0;

    bst_nxt  = bst;
    wait_nxt = wait_cnt;
    case (bst)
      B_IDLE: begin
        if (gnt_b) begin
          bst_nxt  = B_ACK;
          wait_nxt = '0;
        end else if (b_req) begin
          wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WCW'(1);
        end else begin
          wait_nxt = '0;
        end
      end
      B_ACK: bst_nxt = B_IDLE;
      default: bst_nxt = B_IDLE;
    endcase

    dbg_bst      = bst;
    dbg_wait_cnt = wait_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bst      <= B_IDLE;
      wait_cnt <= '0;
      b_rdata  <= '0;
    end else begin
      bst      <= bst_nxt;
      wait_cnt <= wait_nxt;
      // Captured before the write commits, so a B write returns old content.
      if (gnt_b) b_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural asynchronous-read data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr, mem_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic        a_stall, b_ack, mem_we, dbg_bst;
  logic [2:0]  dbg_wait_cnt;
  logic [15:0] mem [256];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_stall(a_stall),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_bst(dbg_bst), .dbg_wait_cnt(dbg_wait_cnt)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick();
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
  endtask

  task automatic preload();
    logic [7:0]  pa [6] = '{8'h33, 8'h02, 8'h05, 8'h06, 8'h40, 8'h10};
    logic [15:0] pd [6] = '{16'h7777, 16'h0020, 16'h0000, 16'h0ABC, 16'h1234, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      tick();
      a_req = 1'b1; a_we = 1'b1; a_addr = pa[i]; a_wdata = pd[i];
    end
    idle();
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1; a_req = 1'b1; a_we = 1'b1; a_addr = 8'h33; a_wdata = 16'hDEAD;
    b_req = 1'b1; b_addr = 8'h02;
    #2;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    vectors++; if (b_ack !== 1'b0) begin miscompares++; $display("FAIL reset_b_ack: got %b want 0", b_ack); end
    vectors++; if (b_rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_b_rdata: got %h want 0000", b_rdata); end
    vectors++; if (a_stall !== 1'b0) begin miscompares++; $display("FAIL reset_a_stall: got %b want 0", a_stall); end
    tick();
    #2;
    vectors++; if (mem[8'h33] !== 16'h7777) begin miscompares++; $display("FAIL reset_no_write: got %h want 7777", mem[8'h33]); end
    vectors++; if (dbg_wait_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_wait_cnt: got %0d want 0", dbg_wait_cnt); end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_a_only();
    tick();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 16'hBEEF;
    #2;
    vectors++; if (a_stall !== 1'b0) begin miscompares++; $display("FAIL a_only_wr_stall: got %b want 0", a_stall); end
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 8'h10) begin miscompares++; $display("FAIL a_only_wr_mem: got we=%b addr=%h want we=1 addr=10", mem_we, mem_addr); end
    tick();
    a_we = 1'b0;
    #2;
    vectors++; if (a_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL a_only_rd: got %h want beef", a_rdata); end
    vectors++; if (a_stall !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL a_only_rd_ctl: got stall=%b we=%b want 0 0", a_stall, mem_we); end
    idle();
  endtask

  task automatic test_b_only();
    tick();
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
    #2;
    vectors++; if (mem_addr !== 8'h02 || b_ack !== 1'b0) begin miscompares++; $display("FAIL b_only_grant: got addr=%h ack=%b want 02 0", mem_addr, b_ack); end
    tick();
    #2;
    vectors++; if (b_ack !== 1'b1 || b_rdata !== 16'h0020) begin miscompares++; $display("FAIL b_only_ack: got ack=%b rdata=%h want 1 0020", b_ack, b_rdata); end
    vectors++; if (dbg_bst !== 1'b1) begin miscompares++; $display("FAIL b_only_state: got %b want 1", dbg_bst); end
    b_req = 1'b0;
    tick();
    #2;
    vectors++; if (b_ack !== 1'b0 || b_rdata !== 16'h0020) begin miscompares++; $display("FAIL b_only_after: got ack=%b rdata=%h want 0 0020", b_ack, b_rdata); end
    idle();
  endtask

  task automatic test_starvation();
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
    #2;
    vectors++; if (dbg_wait_cnt !== 3'd0 || a_stall !== 1'b0 || mem_addr !== 8'h10) begin miscompares++; $display("FAIL starve_c0: got cnt=%0d stall=%b addr=%h want 0 0 10", dbg_wait_cnt, a_stall, mem_addr); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      #2;
      vectors++; if (dbg_wait_cnt !== 3'(i) || a_stall !== 1'b0 || b_ack !== 1'b0) begin miscompares++; $display("FAIL starve_count: got cnt=%0d stall=%b ack=%b want %0d 0 0", dbg_wait_cnt, a_stall, b_ack, i); end
    end
    tick();
    #2;
    vectors++; if (dbg_wait_cnt !== 3'd4 || a_stall !== 1'b1 || mem_addr !== 8'h02) begin miscompares++; $display("FAIL starve_force: got cnt=%0d stall=%b addr=%h want 4 1 02", dbg_wait_cnt, a_stall, mem_addr); end
    tick();
    b_req = 1'b0;
    #2;
    vectors++; if (b_ack !== 1'b1 || a_stall !== 1'b0 || b_rdata !== 16'h0020) begin miscompares++; $display("FAIL starve_ack: got ack=%b stall=%b rdata=%h want 1 0 0020", b_ack, a_stall, b_rdata); end
    vectors++; if (dbg_wait_cnt !== 3'd0 || a_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL starve_ack_misc: got cnt=%0d a_rdata=%h want 0 beef", dbg_wait_cnt, a_rdata); end
    idle();
  endtask

  task automatic test_forced_write();
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h05; a_wdata = 16'h1111;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h06; b_wdata = 16'h2222;
    repeat (4) tick();
    a_we = 1'b1;
    #2;
    vectors++; if (a_stall !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h06 || mem_wdata !== 16'h2222) begin miscompares++; $display("FAIL fw_force: got stall=%b we=%b addr=%h wd=%h want 1 1 06 2222", a_stall, mem_we, mem_addr, mem_wdata); end
    tick();
    b_req = 1'b0;
    #2;
    vectors++; if (mem[8'h06] !== 16'h2222 || mem[8'h05] !== 16'h0000) begin miscompares++; $display("FAIL fw_only_b: got m6=%h m5=%h want 2222 0000", mem[8'h06], mem[8'h05]); end
    vectors++; if (b_ack !== 1'b1 || b_rdata !== 16'h0ABC) begin miscompares++; $display("FAIL fw_b_old: got ack=%b rdata=%h want 1 0abc", b_ack, b_rdata); end
    vectors++; if (a_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h05) begin miscompares++; $display("FAIL fw_a_next: got stall=%b we=%b addr=%h want 0 1 05", a_stall, mem_we, mem_addr); end
    tick();
    a_we = 1'b0;
    #2;
    vectors++; if (a_rdata !== 16'h1111) begin miscompares++; $display("FAIL fw_rd5: got %h want 1111", a_rdata); end
    tick();
    a_addr = 8'h06;
    #2;
    vectors++; if (a_rdata !== 16'h2222) begin miscompares++; $display("FAIL fw_rd6: got %h want 2222", a_rdata); end
    idle();
  endtask

  task automatic test_back_to_back();
    tick();
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
    #2;
    vectors++; if (mem_addr !== 8'h02 || a_stall !== 1'b0 || b_ack !== 1'b0) begin miscompares++; $display("FAIL b2b_c0: got addr=%h stall=%b ack=%b want 02 0 0", mem_addr, a_stall, b_ack); end
    tick();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    #2;
    vectors++; if (b_ack !== 1'b1 || a_stall !== 1'b0 || mem_addr !== 8'h10 || a_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL b2b_ack_a: got ack=%b stall=%b addr=%h rd=%h want 1 0 10 beef", b_ack, a_stall, mem_addr, a_rdata); end
    tick();
    #2;
    vectors++; if (b_ack !== 1'b0 || a_stall !== 1'b0 || dbg_wait_cnt !== 3'd0 || mem_addr !== 8'h10) begin miscompares++; $display("FAIL b2b_a_wins: got ack=%b stall=%b cnt=%0d addr=%h want 0 0 0 10", b_ack, a_stall, dbg_wait_cnt, mem_addr); end
    tick();
    a_req = 1'b0;
    #2;
    vectors++; if (dbg_wait_cnt !== 3'd1 || mem_addr !== 8'h02 || b_ack !== 1'b0) begin miscompares++; $display("FAIL b2b_regrant: got cnt=%0d addr=%h ack=%b want 1 02 0", dbg_wait_cnt, mem_addr, b_ack); end
    tick();
    b_req = 1'b0;
    #2;
    vectors++; if (b_ack !== 1'b1 || b_rdata !== 16'h0020) begin miscompares++; $display("FAIL b2b_ack2: got ack=%b rdata=%h want 1 0020", b_ack, b_rdata); end
    tick();
    #2;
    vectors++; if (b_ack !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got %b want 0", b_ack); end
    idle();
  endtask

  task automatic test_reset_mid_grant();
    tick();
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h40; b_wdata = 16'h5555;
    #2;
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 8'h40) begin miscompares++; $display("FAIL rmg_grant: got we=%b addr=%h want 1 40", mem_we, mem_addr); end
    rst = 1'b1;
    #1;
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rmg_we_gated: got %b want 0", mem_we); end
    tick();
    rst = 1'b0; b_req = 1'b0; b_we = 1'b0;
    #2;
    vectors++; if (b_ack !== 1'b0 || dbg_bst !== 1'b0 || dbg_wait_cnt !== 3'd0) begin miscompares++; $display("FAIL rmg_state: got ack=%b bst=%b cnt=%0d want 0 0 0", b_ack, dbg_bst, dbg_wait_cnt); end
    vectors++; if (mem[8'h40] !== 16'h1234) begin miscompares++; $display("FAIL rmg_no_write: got %h want 1234", mem[8'h40]); end
    tick();
    #2;
    vectors++; if (b_ack !== 1'b0) begin miscompares++; $display("FAIL rmg_no_ack: got %b want 0", b_ack); end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (b_ack !== 1'b0 || b_rdata !== 16'h0000 || dbg_wait_cnt !== 3'd0) begin miscompares++; $display("FAIL init_reset: got ack=%b rdata=%h cnt=%0d want 0 0000 0", b_ack, b_rdata, dbg_wait_cnt); end
    rst = 1'b0;
    preload();
    test_a_only();
    test_b_only();
    test_reset();
    test_starvation();
    test_forced_write();
    test_back_to_back();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
